// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and typedefs for the scoreboarded register file.
// Optional write-through bypass is enabled by defining REGFILE_BYPASS_EN.
package regfile_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);
  localparam int PC_IDX       = DEF_NUM_REGS - 1;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: pending-write busy bits set at issue, cleared at
// writeback or flush.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] wr,
  input  logic              flush,
  output logic [NUM_REGS-1:0] busy
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        // a newer producer supersedes the retiring one
        if (iss_en && iss_rd == ADDR_W'(i))
          busy[i] <= 1'b1;
        else if (write_en && wr == ADDR_W'(i))
          busy[i] <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R/1W register file with PC write port and RAW scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W  = $clog2(NUM_REGS),
  parameter int PC_IDX   = NUM_REGS - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   sr1,
  input  logic [ADDR_W-1:0]   sr2,
  output logic [DATA_W-1:0]   data_out1,
  output logic [DATA_W-1:0]   data_out2,
  input  logic [ADDR_W-1:0]   wr,
  input  logic [DATA_W-1:0]   data_in,
  input  logic                write_en,
  input  logic [DATA_W-1:0]   pc_in,
  input  logic                pc_en,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_rd,
  input  logic                flush,
  output logic                hazard1,
  output logic                hazard2,
  output logic [NUM_REGS-1:0] busy
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic              gen_we;
    logic              pc_we;
    logic [DATA_W-1:0] q;

    assign gen_we = write_en && (wr == ADDR_W'(g));
    if (g == PC_IDX) begin : g_pc
      assign pc_we = pc_en;
    end else begin : g_nopc
      assign pc_we = 1'b0;
    end

    // general writeback wins over the PC port
    always_ff @(posedge clk) begin
      if (rst)
        q <= '0;
      else if (gen_we)
        q <= data_in;
      else if (pc_we)
        q <= pc_in;
    end

    assign regs[g] = q;
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_rd   (iss_rd),
    .write_en (write_en),
    .wr       (wr),
    .flush    (flush),
    .busy     (busy)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  assign byp1      = write_en && (wr == sr1);
  assign byp2      = write_en && (wr == sr2);
  assign data_out1 = byp1 ? data_in : regs[sr1];
  assign data_out2 = byp2 ? data_in : regs[sr2];
  assign hazard1   = busy[sr1] && !byp1;
  assign hazard2   = busy[sr2] && !byp2;
`else
  assign data_out1 = regs[sr1];
  assign data_out2 = regs[sr2];
  assign hazard1   = busy[sr1];
  assign hazard2   = busy[sr2];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scenarios plus randomized run against a
// behavioural register-file/scoreboard model.
module tb_regfile_sb;
  import regfile_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  reg_addr_t   sr1, sr2, wr, iss_rd;
  reg_data_t   data_out1, data_out2, data_in, pc_in;
  logic        write_en, pc_en, iss_en, flush;
  logic        hazard1, hazard2;
  logic [7:0]  busy;

  int checks = 0;
  int errors = 0;

  reg_data_t  m_regs [8];
  logic [7:0] m_busy;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk       (clk),
    .rst       (rst),
    .sr1       (sr1),
    .sr2       (sr2),
    .data_out1 (data_out1),
    .data_out2 (data_out2),
    .wr        (wr),
    .data_in   (data_in),
    .write_en  (write_en),
    .pc_in     (pc_in),
    .pc_en     (pc_en),
    .iss_en    (iss_en),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .busy      (busy)
  );

  task automatic idle();
    rst = 0; write_en = 0; pc_en = 0; iss_en = 0; flush = 0;
    wr = 0; data_in = 0; pc_in = 0; iss_rd = 0;
  endtask

  // Model: apply PC write, then general write (so general wins);
  // clear on writeback, then set on issue (so issue wins).
  task automatic tick();
    if (rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (pc_en) m_regs[PC_IDX] = pc_in;
      if (write_en) m_regs[wr] = data_in;
      if (flush) m_busy = '0;
      else begin
        if (write_en) m_busy[wr] = 1'b0;
        if (iss_en) m_busy[iss_rd] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1; write_en = 1; wr = 3; data_in = 16'hFFFF;
    iss_en = 1; iss_rd = 3; pc_en = 1; pc_in = 16'h5555;
    tick();
    idle();
    sr1 = 3; sr2 = 7;
    #1;
    checks++;
    if (data_out1 !== 16'h0) begin
      errors++; $display("FAIL reset_d1 got %h exp 0000", data_out1);
    end
    checks++;
    if (data_out2 !== 16'h0) begin
      errors++; $display("FAIL reset_d2 got %h exp 0000", data_out2);
    end
    checks++;
    if (busy !== 8'h00 || hazard1 !== 1'b0 || hazard2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_sb busy %h h1 %b h2 %b exp 00 0 0",
               busy, hazard1, hazard2);
    end
  endtask

  task automatic test_write_read();
    idle();
    write_en = 1; wr = 2; data_in = 16'hBEEF;
    sr1 = 2; sr2 = 7;
    tick();
    idle();
    #1;
    checks++;
    if (data_out1 !== 16'hBEEF) begin
      errors++; $display("FAIL wr_rd_d1 got %h exp beef", data_out1);
    end
    checks++;
    if (data_out2 !== 16'h0) begin
      errors++; $display("FAIL wr_rd_d2 got %h exp 0000", data_out2);
    end
  endtask

  task automatic test_pc_conflict();
    idle();
    pc_en = 1; pc_in = 16'h0100;
    write_en = 1; wr = 7; data_in = 16'h1234;
    sr1 = 7;
    tick();
    idle();
    #1;
    checks++;
    if (data_out1 !== 16'h1234) begin
      errors++; $display("FAIL pc_conflict got %h exp 1234", data_out1);
    end
    pc_en = 1; pc_in = 16'h0102;
    tick();
    idle();
    #1;
    checks++;
    if (data_out1 !== 16'h0102) begin
      errors++; $display("FAIL pc_write got %h exp 0102", data_out1);
    end
    checks++;
    if (busy !== 8'h00) begin
      errors++; $display("FAIL pc_busy got %h exp 00", busy);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    iss_en = 1; iss_rd = 4;
    tick();
    idle();
    sr1 = 4;
    #1;
    checks++;
    if (busy !== 8'h10 || hazard1 !== 1'b1) begin
      errors++; $display("FAIL sb_issue busy %h h1 %b exp 10 1", busy, hazard1);
    end
    write_en = 1; wr = 4; data_in = 16'h4444;
    iss_en = 1; iss_rd = 4;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 8'h10) begin
      errors++; $display("FAIL sb_set_wins got %h exp 10", busy);
    end
    write_en = 1; wr = 4; data_in = 16'h4545;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 8'h00 || hazard1 !== 1'b0) begin
      errors++; $display("FAIL sb_clear busy %h h1 %b exp 00 0", busy, hazard1);
    end
    checks++;
    if (data_out1 !== 16'h4545) begin
      errors++; $display("FAIL sb_wb_data got %h exp 4545", data_out1);
    end
  endtask

  task automatic test_flush();
    logic [2:0] rds [3] = '{3'd1, 3'd3, 3'd5};
    idle();
    foreach (rds[k]) begin
      iss_en = 1; iss_rd = rds[k];
      tick();
    end
    idle();
    #1;
    checks++;
    if (busy !== 8'h2A) begin
      errors++; $display("FAIL flush_setup got %h exp 2a", busy);
    end
    flush = 1; iss_en = 1; iss_rd = 6;
    tick();
    idle();
    #1;
    checks++;
    if (busy !== 8'h00) begin
      errors++; $display("FAIL flush got %h exp 00", busy);
    end
  endtask

  task automatic test_bypass();
    reg_data_t exp_d;
    logic      exp_h;
    idle();
    iss_en = 1; iss_rd = 5;
    tick();
    idle();
    write_en = 1; wr = 5; data_in = 16'hA5A5; sr2 = 5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_d = 16'hA5A5; exp_h = 1'b0;
`else
    exp_d = 16'h0000; exp_h = 1'b1;
`endif
    checks++;
    if (data_out2 !== exp_d || hazard2 !== exp_h) begin
      errors++;
      $display("FAIL bypass d2 %h h2 %b exp %h %b",
               data_out2, hazard2, exp_d, exp_h);
    end
    tick();
    idle();
    #1;
    checks++;
    if (data_out2 !== 16'hA5A5 || busy !== 8'h00) begin
      errors++;
      $display("FAIL bypass_after d2 %h busy %h exp a5a5 00", data_out2, busy);
    end
  endtask

  task automatic test_random();
    reg_data_t e1, e2;
    logic      h1, h2;
    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 60) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      write_en = $urandom_range(0, 1);
      pc_en    = ($urandom_range(0, 3) == 0);
      iss_en   = $urandom_range(0, 1);
      wr       = 3'($urandom);
      iss_rd   = 3'($urandom);
      sr1      = 3'($urandom);
      sr2      = 3'($urandom);
      data_in  = 16'($urandom);
      pc_in    = 16'($urandom);
      #1;
      e1 = m_regs[sr1]; h1 = m_busy[sr1];
      e2 = m_regs[sr2]; h2 = m_busy[sr2];
`ifdef REGFILE_BYPASS_EN
      if (write_en && wr == sr1) begin e1 = data_in; h1 = 1'b0; end
      if (write_en && wr == sr2) begin e2 = data_in; h2 = 1'b0; end
`endif
      checks++;
      if (data_out1 !== e1 || data_out2 !== e2) begin
        errors++;
        $display("FAIL rnd_data n=%0d d1 %h d2 %h exp %h %h",
                 n, data_out1, data_out2, e1, e2);
      end
      checks++;
      if (hazard1 !== h1 || hazard2 !== h2 || busy !== m_busy) begin
        errors++;
        $display("FAIL rnd_sb n=%0d h %b%b busy %h exp %b%b %h",
                 n, hazard1, hazard2, busy, h1, h2, m_busy);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    sr1 = 0; sr2 = 0;
    rst = 1;
    tick();
    idle();
    test_reset();
    test_write_read();
    test_pc_conflict();
    test_scoreboard();
    test_flush();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the 8x16 processor register file.
- Generalised width and depth; 2 combinational read ports; 1 general synchronous write port; dedicated PC-register write port.
- Adds a pending-write scoreboard (busy bits) so the decode stage can detect RAW hazards against in-flight writebacks, plus a pipeline flush.
- Sits between decode (read, issue) and writeback (write, clear).

Parameters:
- DATA_W, 16, register width in bits.
- NUM_REGS, 8, number of registers; power of two, >= 2.
- ADDR_W, $clog2(NUM_REGS), register address width (derived; not overridden).
- PC_IDX, NUM_REGS-1, index of the register that also has the dedicated PC write port.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- sr1  in  ADDR_W  read address, port 1.
- sr2  in  ADDR_W  read address, port 2.
- data_out1  out  DATA_W  read data, port 1 (combinational).
- data_out2  out  DATA_W  read data, port 2 (combinational).
- wr  in  ADDR_W  writeback address.
- data_in  in  DATA_W  writeback data.
- write_en  in  1  writeback strobe; writes reg[wr] and clears busy[wr].
- pc_in  in  DATA_W  PC register data.
- pc_en  in  1  writes reg[PC_IDX] from pc_in.
- iss_en  in  1  instruction issued with a destination; sets busy[iss_rd].
- iss_rd  in  ADDR_W  destination of the issuing instruction.
- flush  in  1  clears all busy bits (pipeline squash).
- hazard1  out  1  source sr1 has a pending write.
- hazard2  out  1  source sr2 has a pending write.
- busy  out  NUM_REGS  scoreboard vector, for debug and stall logic.

Behaviour:
- Reset:
  - rst=1 at a rising edge clears every register to 0 and busy to 0.
  - rst overrides all other inputs in that cycle, including mid-operation writes and issues.
  - Outputs after reset: data_out*=0, hazard*=0, busy=0.
- Reads: data_outN = reg[srN], combinational, zero latency. No hardwired-zero register.
- General write: write_en=1 -> reg[wr] <= data_in at the edge; visible on data_out the following cycle.
- PC write: pc_en=1 -> reg[PC_IDX] <= pc_in.
  - Conflict rule: write_en=1 with wr==PC_IDX and pc_en=1 in the same cycle -> general write wins; pc_in is dropped.
- Scoreboard, next-state per bit i, evaluated in this priority order:
  - flush -> busy[i] <= 0; a same-cycle iss_en is also dropped.
  - else iss_en && iss_rd==i -> busy[i] <= 1. Set wins over a same-cycle clear of the same index, because a newer producer supersedes the retiring one.
  - else write_en && wr==i -> busy[i] <= 0.
  - else busy[i] holds.
  - pc_en does not affect busy.
- Write while not busy: legal; data is written and busy stays 0.
- Hazards: hazardN = busy[srN] (combinational from the registered busy vector), unless modified by the optional feature.
- The block never stalls itself; hazards are advisory to the pipeline controller.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - write_en && wr==srN -> data_outN = data_in in the same cycle (write-through).
  - hazardN is forced 0 for that port in that cycle.
  - A PC-port write is not bypassed.
- Undefined: reads return the pre-edge register value; hazardN follows busy[srN] unmodified.

Decomposition:
- Shared package regfile_pkg: DATA_W and NUM_REGS defaults; PC_IDX; typedefs reg_addr_t (ADDR_W bits) and reg_data_t (DATA_W bits).
- Sub-module regfile_scoreboard: holds busy, takes iss_en/iss_rd/write_en/wr/flush/rst, outputs busy.
- The storage array is a plain generate loop of registers with per-index enable, keeping the existing 16-bit register cell style generalised to DATA_W.

Test Plan:
- Reset then read: rst=1 for one cycle; sr1=3, sr2=7 -> data_out1=0, data_out2=0, busy=0x00.
- Write/read: write_en=1, wr=2, data_in=0xBEEF; next cycle sr1=2 -> data_out1=0xBEEF, data_out2 unchanged.
- PC conflict: pc_en=1 with pc_in=0x0100, plus write_en=1 with wr=7 and data_in=0x1234 -> reg7=0x1234. Next cycle pc_en alone with pc_in=0x0102 -> reg7=0x0102.
- Scoreboard:
  - iss_en=1, iss_rd=4 -> busy=0x10; sr1=4 -> hazard1=1.
  - Later write_en wr=4 together with iss_en iss_rd=4 -> busy stays 0x10.
  - Then write_en wr=4 alone -> busy=0x00, hazard1=0.
- Flush: set busy for regs 1,3,5 (0x2A); flush=1 with iss_en iss_rd=6 -> busy=0x00 next cycle.
- Bypass (macro defined): write_en wr=5, data_in=0xA5A5, sr2=5, busy[5]=1 -> same cycle data_out2=0xA5A5, hazard2=0. Without the macro -> data_out2 = old value, hazard2=1.
